// File: rtl/camellia_round_ctrl.sv
// Sequencer for the iterative Camellia-128 datapath: key schedule, whitening, F-rounds with
// interleaved FL layers, and output load. All strobes are registered and decoded one edge ahead.
module camellia_round_ctrl #(
    parameter int ROUNDS    = 18,
    parameter int FL_PERIOD = 6,
    parameter int KS_STEPS  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dec,
    output logic       ld_in,
    output logic       busy,
    output logic       ks_en,
    output logic [1:0] ks_step,
    output logic       ka_ld,
    output logic       wht_en,
    output logic       wht_sel,
    output logic       rnd_en,
    output logic [4:0] rnd_idx,
    output logic       fl_en,
    output logic       fl_idx,
    output logic       ld_out,
    output logic       out_rdy
);

    typedef enum logic [2:0] {IDLE, KS, PRE, RND, FL, POST, OUT} state_t;

    localparam logic [4:0] R_LAST  = 5'(ROUNDS - 1);
    localparam logic [1:0] S_LAST  = 2'(KS_STEPS - 1);
    localparam int         FL_LAST = ROUNDS / FL_PERIOD - 2;

    state_t     state;
    logic [4:0] r;
    logic [1:0] step;
    logic       dec_q;

    // Decryption walks the subkey table from the top down.
    function automatic logic [4:0] rnd_map(input logic [4:0] rr, input logic d);
        return d ? (R_LAST - rr) : rr;
    endfunction

    function automatic logic fl_due(input logic [4:0] rr);
        return ((int'(rr) + 1) % FL_PERIOD) == 0;
    endfunction

    function automatic logic fl_map(input logic [4:0] rr, input logic d);
        int g;
        g = (int'(rr) + 1) / FL_PERIOD - 1;
        return d ? 1'(FL_LAST - g) : 1'(g);
    endfunction

    assign busy  = (state != IDLE);
    assign ld_in = start & ~busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            r       <= '0;
            step    <= '0;
            dec_q   <= 1'b0;
            ks_en   <= 1'b0;
            ks_step <= '0;
            ka_ld   <= 1'b0;
            wht_en  <= 1'b0;
            wht_sel <= 1'b0;
            rnd_en  <= 1'b0;
            rnd_idx <= '0;
            fl_en   <= 1'b0;
            fl_idx  <= 1'b0;
            ld_out  <= 1'b0;
            out_rdy <= 1'b0;
        end else begin
            // Strobes default low; each branch raises those belonging to the state being entered.
            ks_en   <= 1'b0;
            ks_step <= '0;
            ka_ld   <= 1'b0;
            wht_en  <= 1'b0;
            wht_sel <= 1'b0;
            rnd_en  <= 1'b0;
            rnd_idx <= '0;
            fl_en   <= 1'b0;
            fl_idx  <= 1'b0;
            ld_out  <= 1'b0;
            out_rdy <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= KS;
                        step    <= '0;
                        dec_q   <= dec;
                        ks_en   <= 1'b1;
                        ks_step <= '0;
                        ka_ld   <= (S_LAST == 2'd0);
                    end
                end
                KS: begin
                    if (step == S_LAST) begin
                        state   <= PRE;
                        wht_en  <= 1'b1;
                        wht_sel <= dec_q;
                    end else begin
                        step    <= step + 2'd1;
                        ks_en   <= 1'b1;
                        ks_step <= step + 2'd1;
                        ka_ld   <= ((step + 2'd1) == S_LAST);
                    end
                end
                PRE: begin
                    state   <= RND;
                    r       <= '0;
                    rnd_en  <= 1'b1;
                    rnd_idx <= rnd_map(5'd0, dec_q);
                end
                RND: begin
                    if (r == R_LAST) begin
                        state   <= POST;
                        wht_en  <= 1'b1;
                        wht_sel <= ~dec_q;
                    end else if (fl_due(r)) begin
                        state  <= FL;
                        fl_en  <= 1'b1;
                        fl_idx <= fl_map(r, dec_q);
                    end else begin
                        r       <= r + 5'd1;
                        rnd_en  <= 1'b1;
                        rnd_idx <= rnd_map(r + 5'd1, dec_q);
                    end
                end
                FL: begin
                    state   <= RND;
                    r       <= r + 5'd1;
                    rnd_en  <= 1'b1;
                    rnd_idx <= rnd_map(r + 5'd1, dec_q);
                end
                POST: begin
                    state  <= OUT;
                    ld_out <= 1'b1;
                end
                OUT: begin
                    state   <= IDLE;
                    out_rdy <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_camellia_round_ctrl.sv
// Randomized bench for camellia_round_ctrl: a per-cycle schedule of expected strobes is built
// from the block recipe and compared against every DUT output each cycle.
module tb_camellia_round_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       dec;
    logic       ld_in, busy, ks_en, ka_ld, wht_en, wht_sel, rnd_en, fl_en, fl_idx, ld_out, out_rdy;
    logic [1:0] ks_step;
    logic [4:0] rnd_idx;

    camellia_round_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .dec(dec),
        .ld_in(ld_in), .busy(busy), .ks_en(ks_en), .ks_step(ks_step), .ka_ld(ka_ld),
        .wht_en(wht_en), .wht_sel(wht_sel), .rnd_en(rnd_en), .rnd_idx(rnd_idx),
        .fl_en(fl_en), .fl_idx(fl_idx), .ld_out(ld_out), .out_rdy(out_rdy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ks_en;
        logic [1:0] ks_step;
        logic       ka_ld;
        logic       wht_en;
        logic       wht_sel;
        logic       rnd_en;
        logic [4:0] rnd_idx;
        logic       fl_en;
        logic       fl_idx;
        logic       ld_out;
    } ctl_t;

    ctl_t sched[$];
    bit   m_rdy;
    int   edge_cnt;
    int   acc_edge;
    int   n_checks;
    int   n_errors;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s edge=%0d got=%0h expected=%0h", tag, edge_cnt, got, exp);
        end
    endtask

    // One block as the ordered list of active strobes, cycle by cycle.
    task automatic push_block(input logic d);
        ctl_t c;
        for (int s = 0; s < 4; s++) begin
            c = '0; c.ks_en = 1'b1; c.ks_step = 2'(s); c.ka_ld = (s == 3);
            sched.push_back(c);
        end
        c = '0; c.wht_en = 1'b1; c.wht_sel = d;
        sched.push_back(c);
        for (int rr = 0; rr < 18; rr++) begin
            c = '0; c.rnd_en = 1'b1; c.rnd_idx = d ? 5'(17 - rr) : 5'(rr);
            sched.push_back(c);
            if ((rr + 1) % 6 == 0 && rr + 1 < 18) begin
                c = '0; c.fl_en = 1'b1;
                c.fl_idx = d ? 1'(1 - ((rr + 1) / 6 - 1)) : 1'((rr + 1) / 6 - 1);
                sched.push_back(c);
            end
        end
        c = '0; c.wht_en = 1'b1; c.wht_sel = ~d;
        sched.push_back(c);
        c = '0; c.ld_out = 1'b1;
        sched.push_back(c);
    endtask

    task automatic model_step();
        bit nr;
        nr = 1'b0;
        if (sched.size() > 0) begin
            void'(sched.pop_front());
            if (sched.size() == 0) nr = 1'b1;
        end else if (start) begin
            push_block(dec);
            acc_edge = edge_cnt;
        end
        m_rdy = nr;
    endtask

    task automatic model_reset();
        sched.delete();
        m_rdy = 1'b0;
    endtask

    task automatic compare();
        logic [17:0] got, exp;
        ctl_t        c;
        logic        eb;
        eb  = (sched.size() > 0);
        c   = eb ? sched[0] : '0;
        exp = {eb, start & ~eb, m_rdy, c};
        got = {busy, ld_in, out_rdy, ks_en, ks_step, ka_ld, wht_en, wht_sel,
               rnd_en, rnd_idx, fl_en, fl_idx, ld_out};
        chk("outs", 32'(got), 32'(exp));
        if (out_rdy === 1'b1) chk("latency", 32'(edge_cnt - acc_edge), 32'd27);
    endtask

    task automatic cycle();
        @(posedge clk);
        edge_cnt++;
        if (rst) model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        n_checks = 0; n_errors = 0; edge_cnt = 0; acc_edge = -1000;
        start = 1'b0; dec = 1'b0; rst = 1'b0;
        model_reset();
        #1 compare();
        run(3);
        rst = 1'b1;
        run(2);

        // Encrypt block, then decrypt block.
        start = 1'b1; dec = 1'b0; cycle();
        start = 1'b0; run(30);
        start = 1'b1; dec = 1'b1; cycle();
        start = 1'b0; dec = 1'b0; run(30);

        // Starts while busy must be ignored, dec changes must not leak into the block.
        start = 1'b1; dec = 1'b0; cycle();
        for (int k = 1; k < 30; k++) begin
            start = (k == 3 || k == 20);
            dec   = 1'($urandom);
            cycle();
        end
        start = 1'b0; run(3);

        // Reset mid-block aborts it; a fresh start goes straight through.
        start = 1'b1; dec = 1'b1; cycle();
        start = 1'b0; run(10);
        rst = 1'b0;
        #1 model_reset();
        compare();
        run(2);
        rst = 1'b1;
        start = 1'b1; dec = 1'b0; cycle();
        start = 1'b0; run(30);

        // Start held high: back-to-back blocks.
        start = 1'b1;
        for (int k = 0; k < 3 * 28 + 5; k++) begin
            dec = 1'($urandom);
            cycle();
        end
        start = 1'b0; run(30);

        // Random start/dec traffic.
        for (int k = 0; k < 400; k++) begin
            start = ($urandom_range(0, 5) == 0);
            dec   = 1'($urandom);
            cycle();
        end
        start = 1'b0; run(30);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
